// File: rtl/mem_pkg.sv
// Shared sizing constants and word/address types for the data memory.
package mem_pkg;

    localparam int DATA_WIDTH = 8;
    localparam int ADDR_WIDTH = 8;
    localparam int DEPTH      = 2 ** ADDR_WIDTH;

    typedef logic [ADDR_WIDTH-1:0] mem_addr_t;
    typedef logic [DATA_WIDTH-1:0] mem_word_t;

endpackage : mem_pkg

// File: rtl/data_memory.sv
// 256 x 8 data memory: one synchronous write port, one combinational read port.
// An asynchronous reset clears every word; reset also overrides a same-cycle write.
module data_memory
    import mem_pkg::*;
(
    input  logic      clock,
    input  logic      reset,
    input  logic      enable_write,
    input  mem_addr_t write_addr,
    input  mem_addr_t read_addr,
    input  mem_word_t write_data,
    output mem_word_t read_data
);

    mem_word_t r_mem [DEPTH];

    // Whole-array clear is the reason this cannot map onto a plain block RAM.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (enable_write) begin
            r_mem[write_addr] <= write_data;
        end
    end

    // Reads show committed contents only; no bypass of pending write_data.
    assign read_data = r_mem[read_addr];

endmodule : data_memory

// File: tb/tb_data_memory.sv
// Directed self-checking bench for data_memory.
module tb_data_memory;
    import mem_pkg::*;

    logic      clock;
    logic      reset;
    logic      enable_write;
    mem_addr_t write_addr;
    mem_addr_t read_addr;
    mem_word_t write_data;
    mem_word_t read_data;

    int checks   = 0;
    int failures = 0;

    data_memory dut (
        .clock        (clock),
        .reset        (reset),
        .enable_write (enable_write),
        .write_addr   (write_addr),
        .read_addr    (read_addr),
        .write_data   (write_data),
        .read_data    (read_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input mem_word_t obs, input mem_word_t exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic rd(input string tag, input mem_addr_t a, input mem_word_t exp);
        read_addr = a;
        #1;
        chk(tag, read_data, exp);
    endtask

    initial begin
        reset        = 1'b0;
        enable_write = 1'b0;
        write_addr   = '0;
        read_addr    = '0;
        write_data   = '0;

        // Asynchronous reset pulse strictly between clock edges (t=7..10)
        #7 reset = 1'b1;
        #1;
        chk("rst_during_addr0", read_data, 8'h00);
        #2 reset = 1'b0;
        for (int a = 0; a < DEPTH; a++) begin
            read_addr = mem_addr_t'(a);
            #0.5;
            chk($sformatf("rst_sweep_%0d", a), read_data, 8'h00);
        end

        // Sequential writes, each held two cycles
        @(negedge clock);
        enable_write = 1'b1; write_addr = 8'h00; write_data = 8'h04;
        repeat (2) @(posedge clock);
        @(negedge clock);
        write_addr = 8'h01; write_data = 8'h05;
        repeat (2) @(posedge clock);

        // Write disabled on address 2
        @(negedge clock);
        enable_write = 1'b0; write_addr = 8'h02; write_data = 8'h06;
        repeat (2) @(posedge clock);
        @(negedge clock);
        rd("seq_wr_addr0", 8'h00, 8'h04);
        rd("seq_wr_addr1", 8'h01, 8'h05);
        rd("wr_disabled_addr2", 8'h02, 8'h00);

        // Read-during-write, same address
        @(negedge clock);
        read_addr = 8'h10; write_addr = 8'h10; write_data = 8'hA5; enable_write = 1'b1;
        #1;
        chk("rdw_before_edge", read_data, 8'h00);
        @(posedge clock); #1;
        chk("rdw_after_edge", read_data, 8'hA5);
        @(negedge clock);
        enable_write = 1'b0;

        // Last address, then overwrite
        @(negedge clock);
        read_addr = 8'hFF; write_addr = 8'hFF; write_data = 8'hFF; enable_write = 1'b1;
        @(posedge clock); #1;
        chk("top_addr_first", read_data, 8'hFF);
        @(negedge clock);
        write_data = 8'h3C;
        @(posedge clock); #1;
        chk("top_addr_overwrite", read_data, 8'h3C);
        @(negedge clock);
        enable_write = 1'b0;
        rd("addr0_untouched", 8'h00, 8'h04);
        rd("addr10_kept", 8'h10, 8'hA5);

        // Reset asserted in the same cycle as a write: reset wins
        @(negedge clock);
        write_addr = 8'h20; write_data = 8'h77; enable_write = 1'b1; read_addr = 8'h20;
        #2 reset = 1'b1;
        #1;
        chk("rst_async_addr20", read_data, 8'h00);
        rd("rst_async_addrFF", 8'hFF, 8'h00);
        read_addr = 8'h20;
        @(posedge clock); #1;
        chk("rst_blocks_write", read_data, 8'h00);
        @(negedge clock);
        enable_write = 1'b0;
        reset = 1'b0;
        for (int a = 0; a < DEPTH; a++) begin
            read_addr = mem_addr_t'(a);
            #0.5;
            chk($sformatf("rst2_sweep_%0d", a), read_data, 8'h00);
        end

        // First write after reset release lands on the next enabled edge
        @(negedge clock);
        write_addr = 8'h20; write_data = 8'h5A; enable_write = 1'b1; read_addr = 8'h20;
        #1;
        chk("post_rst_before_edge", read_data, 8'h00);
        @(posedge clock); #1;
        chk("post_rst_write", read_data, 8'h5A);
        @(negedge clock);
        enable_write = 1'b0;
        rd("post_rst_other", 8'h21, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_data_memory

// File: doc/data_memory.md
Name: data_memory

Overview:
Byte-wide, 256-entry data memory for the processor datapath. It has one synchronous write port and one independent combinational read port. Load/store logic writes it on the rising clock edge and reads it without latency in the same cycle. An asynchronous reset clears every location to zero.

Parameters:
DATA_WIDTH, 8, width of each stored word and of the data ports
ADDR_WIDTH, 8, width of both address ports
DEPTH, 2**ADDR_WIDTH (256), number of words; every address value is a valid location

Ports:
clock  input  1  system clock; all writes occur on its rising edge
reset  input  1  asynchronous, active-high; clears the whole array
enable_write  input  1  write strobe, sampled on the rising clock edge
write_addr  input  ADDR_WIDTH  location written when enable_write=1
read_addr  input  ADDR_WIDTH  location driven onto read_data
write_data  input  DATA_WIDTH  value stored at write_addr
read_data  output  DATA_WIDTH  combinational contents of mem[read_addr]

Behaviour:
- Storage: array mem[0..DEPTH-1] of DATA_WIDTH bits.
- Reset:
  - Assertion of reset immediately (no clock needed) sets all DEPTH words to 0.
  - While reset is high, writes are ignored and read_data = 0 for any read_addr.
  - After deassertion, the first write takes effect on the next rising clock edge with enable_write=1.
- Write:
  - On each rising clock edge with reset=0 and enable_write=1: mem[write_addr] <= write_data.
  - With enable_write=0 no location changes.
  - Exactly one word is written per edge; other locations hold their values.
- Read:
  - read_data = mem[read_addr], purely combinational with zero-cycle latency.
  - read_data updates whenever read_addr changes or the addressed word is written.
- Read-during-write to the same address:
  - Before the edge, read_data shows the old contents.
  - Immediately after the edge, it shows write_data.
  - There is no bypass of uncommitted write_data.
- Read and write to different addresses in the same cycle are fully independent.
- Address range: all 256 addresses are valid with no wrap logic; 8'hFF is the last word.
- Reset mid-operation: reset asserted in the same cycle as a write wins, and the array ends up all zero.
- Unknown (X) read_addr gives an undefined read_data. Unknown write_addr/enable_write while writing is a usage error with unspecified result.

Decomposition:
- Shared package mem_pkg holds DATA_WIDTH, ADDR_WIDTH and DEPTH constants plus typedefs mem_addr_t (logic [ADDR_WIDTH-1:0]) and mem_word_t (logic [DATA_WIDTH-1:0]).
- There is no sub-module: the block is a single array with a reset/write process and a continuous read assign.

Test Plan:
- Reset: pulse reset high for 3 ns between clock edges, then sweep read_addr 0..255 -> read_data = 8'h00 at every address. The zeroing must occur before any clock edge.
- Sequential writes: with enable_write=1, write 8'h04@0, then 8'h05@1, each held 2 cycles. Set read_addr=0 -> read_data=8'h04; read_addr=1 -> read_data=8'h05 in the same cycle (no latency).
- Write disabled: enable_write=0 with write_addr=2 and write_data=8'h06 for 2 edges, then read_addr=2 -> read_data=8'h00. Addresses 0 and 1 are unchanged at 8'h04 and 8'h05.
- Read-during-write: read_addr=write_addr=8'h10 (holding 8'h00) and write_data=8'hA5 with enable_write=1 -> read_data=8'h00 before the edge and 8'hA5 right after it.
- Boundary and overwrite: write 8'hFF@8'hFF, then 8'h3C@8'hFF. Reading 8'hFF gives 8'hFF after the first edge and 8'h3C after the second; address 8'h00 is unaffected.
- Reset over data: after the writes above, assert reset asynchronously in the same cycle as a write of 8'h77@8'h20 -> all addresses read 8'h00, including 8'h20.
